// File: rtl/lmem_pkg.sv
// Shared definitions for the layer-memory arbiter: requester IDs, memory
// select codes, default widths and the arbiter FSM state type.
package lmem_pkg;

    localparam int N_REQ = 3;
    localparam int AW    = 12;
    localparam int DW    = 20;

    localparam logic [1:0] REQ_CONV = 2'd0;
    localparam logic [1:0] REQ_RELU = 2'd1;
    localparam logic [1:0] REQ_POOL = 2'd2;

    localparam logic [2:0] CSEL_L0 = 3'b001;
    localparam logic [2:0] CSEL_L1 = 3'b011;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

endpackage

// File: rtl/lmem_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first requester at
// or after the pointer, wrapping around the requester count.
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    // Scan upward from the pointer and keep only the first active request
    always_comb begin
        int  idx_s;
        logic found_s;
        gnt     = '0;
        idx_s   = 0;
        found_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx_s = (int'(ptr) + k) % N;
            if (!found_s && req[idx_s]) begin
                gnt[idx_s] = 1'b1;
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/lmem_arbiter.sv
// Layer-memory arbiter: round-robin grant with optional ownership lock,
// registered memory command port and a two-cycle read return path.
module lmem_arbiter
    import lmem_pkg::*;
#(
    parameter int N_REQ = lmem_pkg::N_REQ,
    parameter int AW    = lmem_pkg::AW,
    parameter int DW    = lmem_pkg::DW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    lock,
    input  logic [N_REQ-1:0]    we,
    input  logic [3*N_REQ-1:0]  sel,
    input  logic [AW*N_REQ-1:0] addr,
    input  logic [DW*N_REQ-1:0] wdata,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    rvalid,
    output logic [DW-1:0]       rdata,
    input  logic                quiesce,
    output logic                idle,
    output logic [2:0]          csel,
    output logic                cwr,
    output logic                crd,
    output logic [AW-1:0]       caddr_wr,
    output logic [AW-1:0]       caddr_rd,
    output logic [DW-1:0]       cdata_wr,
    input  logic [DW-1:0]       cdata_rd
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t            state_r, state_nx_s;
    logic [PW-1:0]     ptr_r, ptr_nx_s, owner_r, owner_nx_s;
    logic [N_REQ-1:0]  rr_gnt_s, gnt_s, acc_s, rd_pend_r, rvalid_r;
    logic              acc_any_s, acc_we_s, acc_lock_s, idle_nx_s;
    logic [PW-1:0]     acc_idx_s;
    logic [2:0]        acc_sel_s, csel_r;
    logic [AW-1:0]     acc_addr_s, caddr_wr_r, caddr_rd_r;
    logic [DW-1:0]     acc_wdata_s, cdata_wr_r, rdata_r;
    logic              cwr_r, crd_r, idle_r;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
        if (i == PW'(N_REQ - 1)) return '0;
        else return i + PW'(1);
    endfunction

    rr_pick #(.N(N_REQ), .PW(PW)) u_rr_pick (
        .req (req),
        .ptr (ptr_r),
        .gnt (rr_gnt_s)
    );

    // Grant: round-robin when free, owner-only when locked, none under reset/quiesce
    always_comb begin
        gnt_s = '0;
        if (reset || quiesce) begin
            gnt_s = '0;
        end else begin
            case (state_r)
                ST_IDLE: gnt_s = rr_gnt_s;
                ST_LOCK: begin
                    if (req[owner_r]) gnt_s[owner_r] = 1'b1;
                    else gnt_s = '0;
                end
                default: gnt_s = '0;
            endcase
        end
    end

    // Decode the accepted access and mux out the winner's command fields
    always_comb begin
        acc_s       = req & gnt_s;
        acc_any_s   = |acc_s;
        acc_we_s    = |(acc_s & we);
        acc_lock_s  = |(acc_s & lock);
        acc_idx_s   = '0;
        acc_sel_s   = 3'b000;
        acc_addr_s  = '0;
        acc_wdata_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (acc_s[i]) begin
                acc_idx_s   = PW'(i);
                acc_sel_s   = sel[3*i +: 3];
                acc_addr_s  = addr[AW*i +: AW];
                acc_wdata_s = wdata[DW*i +: DW];
            end else begin
                acc_idx_s = acc_idx_s;
            end
        end
    end

    // Next-state: lock takes ownership, pointer moves past whoever finished
    always_comb begin
        state_nx_s = state_r;
        ptr_nx_s   = ptr_r;
        owner_nx_s = owner_r;
        case (state_r)
            ST_IDLE: begin
                if (acc_any_s && acc_lock_s) begin
                    state_nx_s = ST_LOCK;
                    owner_nx_s = acc_idx_s;
                end else if (acc_any_s) begin
                    ptr_nx_s = wrap_inc(acc_idx_s);
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LOCK: begin
                // Quiesce abandons ownership without rotating the pointer
                if (quiesce) begin
                    state_nx_s = ST_IDLE;
                end else if (!req[owner_r] || (acc_any_s && !acc_lock_s)) begin
                    state_nx_s = ST_IDLE;
                    ptr_nx_s   = wrap_inc(owner_r);
                end else begin
                    state_nx_s = ST_LOCK;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
        idle_nx_s = (state_nx_s == ST_IDLE) && !acc_any_s && (rd_pend_r == '0);
    end

    // Arbitration state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            ptr_r   <= '0;
            owner_r <= '0;
        end else begin
            state_r <= state_nx_s;
            ptr_r   <= ptr_nx_s;
            owner_r <= owner_nx_s;
        end
    end

    // Memory command stage, read-return pipeline and idle flag
    always_ff @(posedge clk) begin
        if (reset) begin
            cwr_r      <= 1'b0;
            crd_r      <= 1'b0;
            csel_r     <= 3'b000;
            caddr_wr_r <= '0;
            caddr_rd_r <= '0;
            cdata_wr_r <= '0;
            rd_pend_r  <= '0;
            rvalid_r   <= '0;
            rdata_r    <= '0;
            idle_r     <= 1'b1;
        end else begin
            cwr_r     <= acc_we_s;
            crd_r     <= acc_any_s && !acc_we_s;
            csel_r    <= acc_sel_s;
            rd_pend_r <= acc_s & ~we;
            rvalid_r  <= rd_pend_r;
            idle_r    <= idle_nx_s;
            if (acc_we_s) begin
                caddr_wr_r <= acc_addr_s;
                cdata_wr_r <= acc_wdata_s;
            end
            if (acc_any_s && !acc_we_s) caddr_rd_r <= acc_addr_s;
            if (|rd_pend_r) rdata_r <= cdata_rd;
        end
    end

    assign gnt      = gnt_s;
    assign rvalid   = rvalid_r;
    assign rdata    = rdata_r;
    assign idle     = idle_r;
    assign csel     = csel_r;
    assign cwr      = cwr_r;
    assign crd      = crd_r;
    assign caddr_wr = caddr_wr_r;
    assign caddr_rd = caddr_rd_r;
    assign cdata_wr = cdata_wr_r;

endmodule

// File: tb/tb_lmem_arbiter.sv
// Scoreboard bench for lmem_arbiter: directed stimulus pushes expected memory
// commands and read returns; a negedge monitor pops and compares them.
module tb_lmem_arbiter;

    logic        clk, reset, quiesce, idle, cwr, crd;
    logic [2:0]  req, lock, we, gnt, rvalid, csel;
    logic [8:0]  sel;
    logic [35:0] addr;
    logic [59:0] wdata;
    logic [19:0] rdata, cdata_wr, cdata_rd;
    logic [11:0] caddr_wr, caddr_rd;

    typedef struct packed {
        logic [2:0]  sel;
        logic [11:0] addr;
        logic [19:0] data;
    } op_t;
    typedef struct packed {
        logic [2:0]  rv;
        logic [19:0] data;
    } ret_t;

    op_t  exp_wr[$];
    op_t  exp_rd[$];
    ret_t exp_ret[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic mon_en = 1'b0;

    lmem_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we), .sel(sel),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .quiesce(quiesce), .idle(idle), .csel(csel), .cwr(cwr), .crd(crd),
        .caddr_wr(caddr_wr), .caddr_rd(caddr_rd), .cdata_wr(cdata_wr),
        .cdata_rd(cdata_rd)
    );

    // Layer memory model: read data is a fixed function of the read address
    assign cdata_rd = crd ? (20'h0A000 + {8'h00, caddr_rd}) : 20'h00000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic w, input logic [2:0] s,
                           input logic [11:0] a, input logic [19:0] d);
        we[i]          = w;
        sel[3*i +: 3]  = s;
        addr[12*i +: 12] = a;
        wdata[20*i +: 20] = d;
    endtask

    task automatic push_wr(input logic [2:0] s, input logic [11:0] a, input logic [19:0] d);
        op_t e;
        e.sel = s; e.addr = a; e.data = d;
        exp_wr.push_back(e);
    endtask

    task automatic push_rd(input logic [2:0] s, input logic [11:0] a);
        op_t e;
        e.sel = s; e.addr = a; e.data = 20'h00000;
        exp_rd.push_back(e);
    endtask

    task automatic push_ret(input logic [2:0] rv, input logic [19:0] d);
        ret_t e;
        e.rv = rv; e.data = d;
        exp_ret.push_back(e);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every memory command and read return against the queues
    always @(negedge clk) begin
        if (mon_en) begin
            if (cwr) begin
                n_cmp++;
                if (exp_wr.size() == 0) begin
                    n_err++;
                    $display("FAIL wr_unexpected: actual write to %0h required none", caddr_wr);
                end else begin
                    op_t e;
                    e = exp_wr.pop_front();
                    check("wr_csel", 32'(csel), 32'(e.sel));
                    check("wr_addr", 32'(caddr_wr), 32'(e.addr));
                    check("wr_data", 32'(cdata_wr), 32'(e.data));
                    check("wr_no_crd", 32'(crd), 32'(1'b0));
                end
            end
            if (crd) begin
                n_cmp++;
                if (exp_rd.size() == 0) begin
                    n_err++;
                    $display("FAIL rd_unexpected: actual read of %0h required none", caddr_rd);
                end else begin
                    op_t e;
                    e = exp_rd.pop_front();
                    check("rd_csel", 32'(csel), 32'(e.sel));
                    check("rd_addr", 32'(caddr_rd), 32'(e.addr));
                end
            end
            if (rvalid != 3'b000) begin
                n_cmp++;
                if (exp_ret.size() == 0) begin
                    n_err++;
                    $display("FAIL ret_unexpected: actual rvalid %0h required none", rvalid);
                end else begin
                    ret_t e;
                    e = exp_ret.pop_front();
                    check("ret_rvalid", 32'(rvalid), 32'(e.rv));
                    check("ret_rdata", 32'(rdata), 32'(e.data));
                end
            end
        end
    end

    logic [2:0]  rr_seq [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [11:0] lk_addr [4] = '{12'h000, 12'h001, 12'h040, 12'h041};
    logic [19:0] lk_data [4] = '{20'h0A000, 20'h0A001, 20'h0A040, 20'h0A041};
    logic [2:0]  rr_sel [3] = '{3'b001, 3'b011, 3'b001};

    initial begin
        reset = 1'b1; quiesce = 1'b0; req = 3'b111; lock = 3'b000; we = 3'b111;
        sel = '0; addr = '0; wdata = '0;
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, rr_sel[i], 12'h010 + 12'(i), 20'h00100 + 20'(i));
        step(); step();
        // Reset state, and no grant while reset is held with requests pending
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'(3'b000));
        check("rst_idle", 32'(idle), 32'(1'b1));
        check("rst_cwr_crd", 32'({cwr, crd}), 32'(2'b00));
        check("rst_csel", 32'(csel), 32'(3'b000));
        check("rst_rvalid", 32'(rvalid), 32'(3'b000));
        check("rst_rdata", 32'(rdata), 32'(20'h00000));
        step();
        reset = 1'b0; mon_en = 1'b1;

        // Round-robin rotation with all three requesting writes
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rr_gnt", 32'(gnt), 32'(rr_seq[k]));
            step();
            push_wr(rr_sel[k % 3], 12'h010 + 12'(k % 3), 20'h00100 + 20'(k % 3));
        end
        req = 3'b000;

        // Single relu write, then command port returns to quiet with held fields
        set_req(1, 1'b1, 3'b001, 12'h0FF, 20'h12345);
        req = 3'b010;
        @(negedge clk);
        check("wr1_gnt", 32'(gnt), 32'(3'b010));
        step();
        push_wr(3'b001, 12'h0FF, 20'h12345);
        req = 3'b000;
        @(negedge clk);
        check("wr1_cwr", 32'(cwr), 32'(1'b1));
        step();
        @(negedge clk);
        check("wr1_cwr_off", 32'(cwr), 32'(1'b0));
        check("wr1_csel_off", 32'(csel), 32'(3'b000));
        check("wr1_addr_hold", 32'(caddr_wr), 32'(12'h0FF));
        check("wr1_data_hold", 32'(cdata_wr), 32'(20'h12345));
        step();

        // Pool holds a lock for four reads while conv keeps requesting
        set_req(0, 1'b1, 3'b011, 12'h020, 20'h00ABC);
        req = 3'b101;
        for (int k = 0; k < 4; k++) begin
            set_req(2, 1'b0, 3'b011, lk_addr[k], 20'h00000);
            lock = (k < 3) ? 3'b100 : 3'b000;
            @(negedge clk);
            check("lk_gnt_pool", 32'(gnt), 32'(3'b100));
            check("lk_gnt_conv", 32'(gnt[0]), 32'(1'b0));
            step();
            push_rd(3'b011, lk_addr[k]);
            push_ret(3'b100, lk_data[k]);
        end
        req = 3'b001; lock = 3'b000;
        @(negedge clk);
        check("lk_conv_after", 32'(gnt), 32'(3'b001));
        step();
        push_wr(3'b011, 12'h020, 20'h00ABC);
        req = 3'b000;
        repeat (3) step();

        // Read accepted, then quiesce: no further grants, single return, idle after
        set_req(1, 1'b0, 3'b001, 12'h123, 20'h00000);
        req = 3'b010;
        @(negedge clk);
        check("q_gnt", 32'(gnt), 32'(3'b010));
        step();
        push_rd(3'b001, 12'h123);
        push_ret(3'b010, 20'h0A123);
        quiesce = 1'b1;
        @(negedge clk);
        check("q_gnt_t1", 32'(gnt), 32'(3'b000));
        check("q_idle_t1", 32'(idle), 32'(1'b0));
        step();
        @(negedge clk);
        check("q_gnt_t2", 32'(gnt), 32'(3'b000));
        check("q_rvalid_t2", 32'(rvalid), 32'(3'b010));
        check("q_idle_t2", 32'(idle), 32'(1'b0));
        step();
        @(negedge clk);
        check("q_gnt_t3", 32'(gnt), 32'(3'b000));
        check("q_rvalid_t3", 32'(rvalid), 32'(3'b000));
        check("q_idle_t3", 32'(idle), 32'(1'b1));
        step();
        quiesce = 1'b0; req = 3'b000;

        // Quiesce breaks a lock without advancing the pointer (still at 2)
        set_req(0, 1'b1, 3'b001, 12'h200, 20'h00200);
        set_req(1, 1'b1, 3'b001, 12'h201, 20'h00201);
        req = 3'b011; lock = 3'b011;
        @(negedge clk);
        check("ql_gnt", 32'(gnt), 32'(3'b001));
        step();
        push_wr(3'b001, 12'h200, 20'h00200);
        quiesce = 1'b1;
        @(negedge clk);
        check("ql_gnt_q", 32'(gnt), 32'(3'b000));
        step();
        quiesce = 1'b0; lock = 3'b000;
        @(negedge clk);
        check("ql_ptr_kept", 32'(gnt), 32'(3'b001));
        step();
        push_wr(3'b001, 12'h200, 20'h00200);
        req = 3'b000;
        repeat (2) step();

        // Reset between read accept and data return drops the return
        set_req(1, 1'b0, 3'b011, 12'h055, 20'h00000);
        req = 3'b010;
        @(negedge clk);
        check("rr_gnt_pre", 32'(gnt), 32'(3'b010));
        step();
        push_rd(3'b011, 12'h055);
        reset = 1'b1;
        @(negedge clk);
        check("rr_gnt_in_reset", 32'(gnt), 32'(3'b000));
        step();
        reset = 1'b0; req = 3'b000;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rr_rvalid", 32'(rvalid), 32'(3'b000));
            check("rr_idle", 32'(idle), 32'(1'b1));
            check("rr_cmd", 32'({cwr, crd, csel}), 32'(5'b00000));
            check("rr_addr", 32'({caddr_wr, caddr_rd}), 32'(24'h000000));
            check("rr_data", 32'(cdata_wr), 32'(20'h00000));
            check("rr_rdata", 32'(rdata), 32'(20'h00000));
            step();
        end

        @(negedge clk);
        check("left_wr", 32'(exp_wr.size()), 32'(0));
        check("left_rd", 32'(exp_rd.size()), 32'(0));
        check("left_ret", 32'(exp_ret.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
